// File: rtl/mul_share_pkg.sv
// Shared definitions for the shared-multiplier arbiter (mul16_share_arb)
// and its helpers.
//   OPW       operand width of the shared multiplier
//   PRODW     full-precision product width
//   NREQ_MAX  largest supported requester count
//   op_t      signed operand type
//   prod_t    signed product type
//   id_width  width of a requester index for n requesters
package mul_share_pkg;

    localparam int OPW      = 16;
    localparam int PRODW    = 32;
    localparam int NREQ_MAX = 16;

    typedef logic signed [OPW-1:0]   op_t;
    typedef logic signed [PRODW-1:0] prod_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/muls16.sv
// Combinational 16x16 signed multiplier, full 32-bit product.
//   a  signed multiplicand
//   b  signed multiplier
//   y  signed product
module muls16 (
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] y
);

    assign y = a * b;

endmodule

// File: rtl/rr_arb.sv
// Round-robin one-hot picker.  Searches valid starting at ptr and
// wrapping.  The grant is only driven while en is high; gidx always shows
// the current candidate.  The pointer register lives with the caller.
//   valid  request vector
//   ptr    search start index
//   en     grant enable
//   grant  one-hot grant (all zero when en low or no request)
//   gidx   index of the candidate
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // (ptr + k) mod NREQ without a divider
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[IDW-1:0];
            if (!found && valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found && en) begin
            grant[gidx] = 1'b1;
        end
    end

endmodule

// File: rtl/mul16_share_arb.sv
// Shares one combinational 16x16 signed multiplier among NREQ requesters.
// Round-robin arbitration, registered operand stage (S1) and registered
// result stage (S2); responses leave in grant order tagged with the
// requester index.  Define MUL_SHARE_PIPE_EN to insert an extra register
// (S1b) after the multiplier, raising latency from 2 to 3 cycles.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept (one-hot or zero)
//   req_a      packed signed multiplicands, 16 bits per requester
//   req_b      packed signed multipliers, 16 bits per requester
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_y      signed 32-bit product
//   rsp_id     requester index that issued the operands
module mul16_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [PRODW-1:0]    rsp_y,
    output logic [IDW-1:0]      rsp_id
);

    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("mul16_share_arb: NREQ out of range");
    end

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gidx;
    logic [NREQ-1:0] grant;
    logic            hs;
    logic            s1_load;
    logic            s2_load;
    op_t             a_sel;
    op_t             b_sel;

    op_t             a_p1;
    op_t             b_p1;
    logic [IDW-1:0]  id_p1;
    logic            vld_p1;
    prod_t           y_p1;

    prod_t           s2_y;
    logic [IDW-1:0]  s2_id;
    logic            s2_vld;

    assign s2_load = !rsp_valid || rsp_ready;

    // Ready is forced low while reset is asserted so no handshake can
    // occur against a pipeline that is being cleared.
    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .en    (s1_load && rst_n),
        .grant (grant),
        .gidx  (gidx)
    );

    assign req_ready = grant;
    assign hs        = |grant;

    always_comb begin
        a_sel = op_t'(req_a[OPW*int'(gidx) +: OPW]);
        b_sel = op_t'(req_b[OPW*int'(gidx) +: OPW]);
    end

    // ---- S1: operand register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (hs) begin
                ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
            end
            if (s1_load) begin
                vld_p1 <= hs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            a_p1  <= a_sel;
            b_p1  <= b_sel;
            id_p1 <= gidx;
        end
    end

    muls16 u_mul (
        .a (a_p1),
        .b (b_p1),
        .y (y_p1)
    );

`ifdef MUL_SHARE_PIPE_EN
    logic            vld_p1b;
    prod_t           y_p1b;
    logic [IDW-1:0]  id_p1b;
    logic            s1b_load;

    assign s1b_load = !vld_p1b || s2_load;
    assign s1_load  = !vld_p1 || s1b_load;

    // ---- S1b: product retiming register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1b <= 1'b0;
        end else if (s1b_load) begin
            vld_p1b <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (s1b_load && vld_p1) begin
            y_p1b  <= y_p1;
            id_p1b <= id_p1;
        end
    end

    assign s2_vld = vld_p1b;
    assign s2_y   = y_p1b;
    assign s2_id  = id_p1b;
`else
    assign s1_load = !vld_p1 || s2_load;
    assign s2_vld  = vld_p1;
    assign s2_y    = y_p1;
    assign s2_id   = id_p1;
`endif

    // ---- S2: result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
        end else if (s2_load) begin
            rsp_valid <= s2_vld;
            if (s2_vld) begin
                rsp_y  <= s2_y;
                rsp_id <= s2_id;
            end
        end
    end

endmodule

// File: tb/tb_mul16_share_arb.sv
// Directed testbench for mul16_share_arb (NREQ = 4).
module tb_mul16_share_arb;

    localparam int NREQ = 4;
`ifdef MUL_SHARE_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_y;
    logic [1:0]        rsp_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul16_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_y !== 32'h0) begin failures++; $display("FAIL reset_rsp_y got=%h want=00000000", rsp_y); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        req_valid = '0;
        rst_n     = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL post_reset_rsp_valid got=%b want=0", rsp_valid); end
    endtask

    // All four requesters valid continuously from ptr = 0.
    task automatic test_all4();
        logic [15:0] ta [4];
        logic [15:0] tb [4];
        logic [31:0] ty [4];
        logic [3:0]  erdy;
        logic [1:0]  eid;
        ta = '{16'd3, 16'hFFF9, 16'd100, 16'h8000};
        tb = '{16'd4, 16'd9, 16'hFFFB, 16'hFFFF};
        ty = '{32'd12, 32'hFFFFFFC1, 32'hFFFFFE0C, 32'h00008000};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, ta[i], tb[i]);
        for (int w = 0; w < 8 + LAT; w++) begin
            if (w == 8) req_valid = '0;
            #1;
            if (w < 8) begin
                erdy = 4'b0001 << (w % 4);
                checks++; if (req_ready !== erdy) begin failures++; $display("FAIL all4_grant w=%0d got=%b want=%b", w, req_ready, erdy); end
            end
            if (w < LAT) begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL all4_early_valid w=%0d got=%b want=0", w, rsp_valid); end
            end else begin
                eid = 2'((w - LAT) % 4);
                checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL all4_valid w=%0d got=%b want=1", w, rsp_valid); end
                checks++; if (rsp_id !== eid) begin failures++; $display("FAIL all4_id w=%0d got=%0d want=%0d", w, rsp_id, eid); end
                checks++; if (rsp_y !== ty[eid]) begin failures++; $display("FAIL all4_y w=%0d got=%h want=%h", w, rsp_y, ty[eid]); end
            end
            tick();
        end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL all4_drain got=%b want=0", rsp_valid); end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_req(0, 16'hFFFD, 16'd5);
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b want=0001", req_ready); end
        tick();
        req_valid = '0;
        for (int i = 0; i < LAT - 1; i++) begin
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid i=%0d got=%b want=0", i, rsp_valid); end
            tick();
        end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b want=1", rsp_valid); end
        checks++; if (rsp_y !== 32'hFFFFFFF1) begin failures++; $display("FAIL single_y got=%h want=fffffff1", rsp_y); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d want=0", rsp_id); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_after got=%b want=0", rsp_valid); end
    endtask

    task automatic test_extremes();
        logic [15:0] va [2];
        logic [15:0] vb [2];
        logic [31:0] vy [2];
        int t;
        va = '{16'h8000, 16'h7FFF};
        vb = '{16'h8000, 16'h8000};
        vy = '{32'h40000000, 32'hC0008000};
        rsp_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            set_req(2, va[v], vb[v]);
            #1;
            t = 0;
            while (req_ready[2] !== 1'b1 && t < 20) begin tick(); t++; end
            checks++; if (req_ready[2] !== 1'b1) begin failures++; $display("FAIL ext_grant_timeout v=%0d got=%b want=1", v, req_ready[2]); end
            tick();
            req_valid = '0;
            t = 0;
            while (rsp_valid !== 1'b1 && t < 20) begin tick(); t++; end
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL ext_rsp_timeout v=%0d got=%b want=1", v, rsp_valid); end
            checks++; if (rsp_y !== vy[v]) begin failures++; $display("FAIL ext_y v=%0d got=%h want=%h", v, rsp_y, vy[v]); end
            checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL ext_id v=%0d got=%0d want=2", v, rsp_id); end
            tick();
        end
    endtask

    // Backpressure: pipeline filled with rsp_ready low, then released.
    task automatic test_stall();
        logic [31:0] ey [3];
        logic [3:0]  hsv;
        int n;
        ey = '{32'h00010000, 32'h00000001, 32'hFFFFF65C};
        rsp_ready = 1'b0;
        set_req(0, 16'h0100, 16'h0100);
        set_req(1, 16'hFFFF, 16'hFFFF);
        set_req(2, 16'd1234, 16'hFFFE);
        for (int w = 0; w < 4; w++) begin
            #1;
            hsv = req_ready & req_valid;
            tick();
            req_valid = req_valid & ~hsv;
        end
        for (int w = 0; w < 5; w++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready w=%0d got=%b want=0000", w, req_ready); end
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_valid w=%0d got=%b want=1", w, rsp_valid); end
            checks++; if (rsp_y !== ey[0]) begin failures++; $display("FAIL stall_y w=%0d got=%h want=%h", w, rsp_y, ey[0]); end
            checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL stall_id w=%0d got=%0d want=0", w, rsp_id); end
            tick();
        end
        rsp_ready = 1'b1;
        n = 0;
        for (int w = 0; w < 12; w++) begin
            #1;
            hsv = req_ready & req_valid;
            if (rsp_valid === 1'b1) begin
                if (n < 3) begin
                    checks++; if (rsp_id !== 2'(n)) begin failures++; $display("FAIL stall_rel_id n=%0d got=%0d want=%0d", n, rsp_id, n); end
                    checks++; if (rsp_y !== ey[n]) begin failures++; $display("FAIL stall_rel_y n=%0d got=%h want=%h", n, rsp_y, ey[n]); end
                end
                n++;
            end
            tick();
            req_valid = req_valid & ~hsv;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL stall_count got=%0d want=3", n); end
        req_valid = '0;
    endtask

    // Bring ptr to 2 via requester 1, then race requesters 1 and 3.
    task automatic test_pair();
        logic [1:0]  eid [3];
        logic [31:0] ey [3];
        int t;
        int n;
        eid = '{2'd3, 2'd1, 2'd2};
        ey  = '{32'd100, 32'hFFFFFFFB, 32'd6};
        rsp_ready = 1'b1;
        set_req(1, 16'd2, 16'd3);
        #1;
        t = 0;
        while (req_ready[1] !== 1'b1 && t < 20) begin tick(); t++; end
        checks++; if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL pair_pre_timeout got=%b want=1", req_ready[1]); end
        tick();
        req_valid = '0;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 20) begin tick(); t++; end
        checks++; if (rsp_y !== 32'd6 || rsp_id !== 2'd1) begin failures++; $display("FAIL pair_pre_rsp got=%h/%0d want=00000006/1", rsp_y, rsp_id); end
        tick();
        n = 0;
        for (int w = 0; w < 10; w++) begin
            case (w)
                0: begin set_req(1, 16'hFFFF, 16'd5); set_req(3, 16'd10, 16'd10); end
                1: req_valid[3] = 1'b0;
                2: begin
                    req_valid = '0;
                    set_req(0, 16'd7, 16'd7);
                    set_req(1, 16'd8, 16'd8);
                    set_req(2, 16'hFFFE, 16'hFFFD);
                    set_req(3, 16'd9, 16'd9);
                end
                default: req_valid = '0;
            endcase
            #1;
            if (w == 0) begin
                checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL pair_first got=%b want=1000", req_ready); end
            end
            if (w == 1) begin
                checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL pair_second got=%b want=0010", req_ready); end
            end
            if (w == 2) begin
                checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL pair_ptr2 got=%b want=0100", req_ready); end
            end
            if (rsp_valid === 1'b1) begin
                if (n < 3) begin
                    checks++; if (rsp_id !== eid[n]) begin failures++; $display("FAIL pair_id n=%0d got=%0d want=%0d", n, rsp_id, eid[n]); end
                    checks++; if (rsp_y !== ey[n]) begin failures++; $display("FAIL pair_y n=%0d got=%h want=%h", n, rsp_y, ey[n]); end
                end
                n++;
            end
            tick();
        end
        checks++; if (n != 3) begin failures++; $display("FAIL pair_count got=%0d want=3", n); end
        req_valid = '0;
    endtask

    task automatic test_reset_flight();
        logic [3:0] hsv;
        rsp_ready = 1'b0;
        set_req(0, 16'd5, 16'd5);
        set_req(1, 16'd6, 16'd6);
        for (int w = 0; w < 2; w++) begin
            #1;
            hsv = req_ready & req_valid;
            tick();
            req_valid = req_valid & ~hsv;
        end
        checks++; if (req_valid !== 4'b0000) begin failures++; $display("FAIL rf_issue got=%b want=0000", req_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rf_async_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_y !== 32'h0) begin failures++; $display("FAIL rf_async_y got=%h want=00000000", rsp_y); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rf_async_ready got=%b want=0000", req_ready); end
        tick();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int w = 0; w < 6; w++) begin
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rf_stale w=%0d got=%b want=0", w, rsp_valid); end
            tick();
        end
        for (int i = 0; i < 4; i++) set_req(i, 16'd1, 16'd1);
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rf_ptr got=%b want=0001", req_ready); end
        tick();
        req_valid = '0;
        repeat (LAT + 1) tick();
    endtask

    initial begin
        test_reset();
        test_all4();
        test_single();
        test_extremes();
        test_stall();
        test_pair();
        test_reset_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
